// File: rtl/alu_4bit.sv
// 4-bit ALU with one-cycle registered result and carry/borrow/shift-out flag.
// The result is formed combinationally from A, B and opcode and captured on
// every rising clock edge; synchronous reset clears both outputs.
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] opcode,
  output logic [3:0] Y,
  output logic       carry
);

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  op_e               w_op;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_y;
  logic              w_carry;

  logic [DATA_W-1:0] r_y;
  logic              r_carry;

  assign w_op = op_e'(opcode);

  // Extended add/subtract; the extra MSB is carry-out or borrow (A < B).
  always_comb begin
    w_sum  = {1'b0, A} + {1'b0, B};
    w_diff = {1'b0, A} - {1'b0, B};
  end

  // Operation select; every opcode is defined so no illegal branch exists.
  always_comb begin
    w_y     = '0;
    w_carry = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_y     = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_y     = w_diff[DATA_W-1:0];
        w_carry = w_diff[DATA_W];
      end
      OP_AND: w_y = A & B;
      OP_OR:  w_y = A | B;
      OP_XOR: w_y = A ^ B;
      OP_SHL: begin
        w_y     = {A[DATA_W-2:0], 1'b0};
        w_carry = A[DATA_W-1];
      end
      OP_SHR: begin
        w_y     = {1'b0, A[DATA_W-1:1]};
        w_carry = A[0];
      end
      OP_NOT: w_y = ~A;
      default: begin
        w_y     = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  // Output register; reset wins over any operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_carry <= 1'b0;
    end else begin
      r_y     <= w_y;
      r_carry <= w_carry;
    end
  end

  assign Y     = r_y;
  assign carry = r_carry;

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: the driver pushes the expected registered
// result for each cycle it drives; the monitor pops and compares after each edge.
module tb_alu_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] opcode;
  logic [3:0] Y;
  logic       carry;

  typedef struct {
    logic [3:0] y;
    logic       c;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared;
  int   n_mismatched;

  alu_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .Y      (Y),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent arithmetic reference using plain integers.
  function automatic void ref_model(input int a, input int b, input int op,
                                    output logic [3:0] ey, output logic ec);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      0: begin r = (a + b) % 16;      c = ((a + b) >= 16) ? 1 : 0; end
      1: begin r = (a + 16 - b) % 16; c = (a < b) ? 1 : 0;         end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 16;      c = (a >= 8) ? 1 : 0;        end
      6: begin r = a / 2;             c = a % 2;                   end
      default: r = 15 - a;
    endcase
    ey = 4'(r);
    ec = (c != 0);
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue its expectation.
  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] ey, input logic ec,
                       input string name);
    exp_t e;
    @(negedge clk);
    rst    = r;
    A      = a;
    B      = b;
    opcode = op;
    e.y    = ey;
    e.c    = ec;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: one registered result per edge, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if (Y !== e.y || carry !== e.c) begin
          n_mismatched++;
          $display("FAIL %s: got Y=%0d carry=%0b, expected Y=%0d carry=%0b",
                   e.name, Y, carry, e.y, e.c);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ey;
    logic       ec;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] rop;
    n_compared   = 0;
    n_mismatched = 0;
    rst    = 1'b1;
    A      = 4'd0;
    B      = 4'd0;
    opcode = 3'd0;

    // Reset held two cycles with a live ADD on the inputs, then released.
    drive(1'b1, 4'd3, 4'd1, 3'b000, 4'd0, 1'b0, "reset_cycle1");
    drive(1'b1, 4'd3, 4'd1, 3'b000, 4'd0, 1'b0, "reset_cycle2");
    drive(1'b0, 4'd3, 4'd1, 3'b000, 4'd4, 1'b0, "first_after_reset");

    // A=3, B=1 through every opcode.
    drive(1'b0, 4'd3, 4'd1, 3'b000, 4'd4,  1'b0, "add_3_1");
    drive(1'b0, 4'd3, 4'd1, 3'b001, 4'd2,  1'b0, "sub_3_1");
    drive(1'b0, 4'd3, 4'd1, 3'b010, 4'd1,  1'b0, "and_3_1");
    drive(1'b0, 4'd3, 4'd1, 3'b011, 4'd3,  1'b0, "or_3_1");
    drive(1'b0, 4'd3, 4'd1, 3'b100, 4'd2,  1'b0, "xor_3_1");
    drive(1'b0, 4'd3, 4'd1, 3'b101, 4'd6,  1'b0, "shl_3");
    drive(1'b0, 4'd3, 4'd1, 3'b110, 4'd1,  1'b1, "shr_3");
    drive(1'b0, 4'd3, 4'd1, 3'b111, 4'd12, 1'b0, "not_3");

    // Arithmetic boundaries.
    drive(1'b0, 4'd15, 4'd1,  3'b000, 4'd0,  1'b1, "add_wrap_15_1");
    drive(1'b0, 4'd0,  4'd1,  3'b001, 4'd15, 1'b1, "sub_borrow_0_1");
    drive(1'b0, 4'd5,  4'd5,  3'b001, 4'd0,  1'b0, "sub_equal_5_5");
    drive(1'b0, 4'd7,  4'd8,  3'b000, 4'd15, 1'b0, "add_7_8_nocarry");

    // Shifts and NOT on A=9; B set non-zero to confirm it is ignored.
    drive(1'b0, 4'd9, 4'd6, 3'b101, 4'd2, 1'b1, "shl_9");
    drive(1'b0, 4'd9, 4'd6, 3'b110, 4'd4, 1'b1, "shr_9");
    drive(1'b0, 4'd9, 4'd6, 3'b111, 4'd6, 1'b0, "not_9");

    // Other bitwise patterns.
    drive(1'b0, 4'd10, 4'd5,  3'b100, 4'd15, 1'b0, "xor_10_5");
    drive(1'b0, 4'd12, 4'd10, 3'b010, 4'd8,  1'b0, "and_12_10");
    drive(1'b0, 4'd12, 4'd3,  3'b011, 4'd15, 1'b0, "or_12_3");

    // Mid-stream reset during ADD 15+15.
    drive(1'b0, 4'd15, 4'd15, 3'b000, 4'd14, 1'b1, "add_15_15");
    drive(1'b1, 4'd15, 4'd15, 3'b000, 4'd0,  1'b0, "midstream_reset");
    drive(1'b0, 4'd15, 4'd15, 3'b000, 4'd14, 1'b1, "add_15_15_after_reset");

    // Random operations against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      ref_model(int'(ra), int'(rb), int'(rop), ey, ec);
      drive(1'b0, ra, rb, rop, ey, ec, "random");
    end

    // Let the last queued result drain, then confirm nothing was left unchecked.
    @(negedge clk);
    repeat (3) @(posedge clk);
    #2;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 Parameters: none; the data width is fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on rising clk edge.
REQ-004 A  input  4  operand A, unsigned.
REQ-005 B  input  4  operand B, unsigned.
REQ-006 opcode  input  3  operation select.
REQ-007 Y  output  4  registered result.
REQ-008 carry  output  1  registered carry, borrow or shift-out flag.

Function
REQ-009 The block SHALL compute the result combinationally from A, B and opcode, then register it into Y and carry on every rising clk edge when rst=0.
REQ-010 Latency SHALL be exactly 1 cycle: operands and opcode present before edge N appear on Y/carry after edge N.
REQ-011 There SHALL be no handshake or enable; a new operation is accepted every cycle.
REQ-012 opcode 000 ADD: {carry,Y} = A + B, 5-bit sum; carry = bit 4.
REQ-013 opcode 001 SUB: Y = (A - B) mod 16; carry = 1 when A < B (borrow), else 0.
REQ-014 opcode 010 AND: Y = A & B; carry = 0.
REQ-015 opcode 011 OR: Y = A | B; carry = 0.
REQ-016 opcode 100 XOR: Y = A ^ B; carry = 0.
REQ-017 opcode 101 SHL: Y = {A[2:0],1'b0}; carry = A[3]; B ignored.
REQ-018 opcode 110 SHR (logical): Y = {1'b0,A[3:1]}; carry = A[0]; B ignored.
REQ-019 opcode 111 NOT: Y = ~A; carry = 0; B ignored.
REQ-020 ADD wrap-around: A=15,B=1 SHALL give Y=0, carry=1.
REQ-021 SUB with A=B SHALL give Y=0, carry=0; A=0,B=1 SHALL give Y=15, carry=1.
REQ-022 X/Z on inputs need not be handled; all 8 opcodes are defined, so no default/illegal case exists.
REQ-023 Outputs SHALL change only on rising clk edges; no combinational path from inputs to Y/carry.

Reset
REQ-024 When rst=1 at a rising edge, Y SHALL become 4'b0000 and carry 1'b0, regardless of A, B, opcode.
REQ-025 Reset SHALL take priority over any operation; an operation presented in a reset cycle is discarded.
REQ-026 After rst is deasserted, the first edge with rst=0 SHALL register the current operation normally (no extra warm-up cycle).
REQ-027 Before the first reset, output values are undefined; the bench SHALL apply reset first.

Verification
REQ-028 rst=1 for 2 cycles with A=3,B=1,opcode=000 -> Y=0, carry=0; release -> next edge Y=4, carry=0.
REQ-029 A=3,B=1, opcode stepped 000..110 one per cycle -> Y=4,2,1,3,2,6,1; carry=0,0,0,0,0,0,1, each one cycle after the opcode is applied.
REQ-030 A=15,B=1 ADD -> Y=0, carry=1; A=0,B=1 SUB -> Y=15, carry=1.
REQ-031 A=9 (1001), SHL -> Y=2, carry=1; SHR -> Y=4, carry=1; NOT -> Y=6, carry=0.
REQ-032 rst asserted mid-stream during ADD A=15,B=15 -> Y=0, carry=0 on that edge; the following edge with rst=0 -> Y=14, carry=1.
REQ-033 Random A, B, opcode for at least 1000 cycles, compared against a 1-cycle-delayed reference model -> zero mismatches.
